// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 binary-coded-modulation scan engine.
package hub75_pkg;

    typedef enum logic [1:0] {WAIT_LINE, SHIFT, LATCH_WAIT, LATCH} scan_state_t;
    typedef enum logic [1:0] {STEP_FETCH, STEP_LOAD, STEP_CLOCK} shift_step_t;

    // Channel order inside one chain's 6-pin group
    localparam int R0 = 0;
    localparam int G0 = 1;
    localparam int B0 = 2;
    localparam int R1 = 3;
    localparam int G1 = 4;
    localparam int B1 = 5;
    localparam int CHANNELS = 6;

    // Must hold BASE_TICKS << (COLOR_BITS-1); never narrower than COLOR_BITS+CLK_DIV.
    function automatic int show_cnt_width(int color_bits, int base_ticks, int clk_div);
        int w;
        w = $clog2(base_ticks) + color_bits;
        if (w < color_bits + clk_div) w = color_bits + clk_div;
        return w;
    endfunction

endpackage

// File: rtl/hub75_clk_gen.sv
// LED shift-clock divider: led_clk toggles every CLK_DIV cycles while run is high,
// with one-cycle strobes in the cycle before each edge.
module hub75_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic led_clk,
    output logic rise_en,
    output logic fall_en
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap    = run && (cnt == CNT_W'(CLK_DIV - 1));
    assign rise_en = wrap && !led_clk;
    assign fall_en = wrap && led_clk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            led_clk <= 1'b0;
        end else if (!run) begin
            cnt     <= '0;
            led_clk <= 1'b0;
        end else if (wrap) begin
            cnt     <= '0;
            led_clk <= ~led_clk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hub75_bcm_scanner.sv
// HUB75 scan engine: shifts one bit-plane per pass from the line buffer and lights
// plane b for BASE_TICKS<<b cycles, overlapping the next plane's shift with the show.
module hub75_bcm_scanner
    import hub75_pkg::*;
#(
    parameter int CHAINS     = 1,
    parameter int PIXELS     = 64,
    parameter int SCAN_LINES = 16,
    parameter int COLOR_BITS = 8,
    parameter int CLK_DIV    = 2,
    parameter int BASE_TICKS = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  line_valid,
    output logic                                  line_ack,
    output logic [$clog2(PIXELS)-1:0]             rd_addr,
    output logic                                  rd_en,
    input  logic [CHAINS*CHANNELS*COLOR_BITS-1:0] rd_data,
    output logic [CHAINS*CHANNELS-1:0]            rgb,
    output logic                                  led_clk,
    output logic                                  strobe,
    output logic                                  oe,
    output logic [$clog2(SCAN_LINES)-1:0]         line_select,
    output logic                                  frame_done
);
    localparam int NBITS   = CHAINS * CHANNELS;
    localparam int COL_W   = $clog2(PIXELS);
    localparam int LINE_W  = $clog2(SCAN_LINES);
    localparam int PLANE_W = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
    localparam int SHOW_W  = show_cnt_width(COLOR_BITS, BASE_TICKS, CLK_DIV);

    scan_state_t state, next_state;
    shift_step_t step;

    logic [COL_W-1:0]   col;
    logic [PLANE_W-1:0] plane;
    logic [LINE_W-1:0]  line;
    logic [SHOW_W-1:0]  show_cnt;
    logic               row_done;
    logic               run, rise_en, fall_en, last_plane;

    logic [NBITS-1:0][COLOR_BITS-1:0] chan;
    logic [NBITS-1:0]                 plane_bits;

    hub75_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .led_clk (led_clk),
        .rise_en (rise_en),
        .fall_en (fall_en)
    );

    assign chan = rd_data;
    always_comb begin
        plane_bits = '0;
        for (int i = 0; i < NBITS; i++) plane_bits[i] = chan[i][plane];
    end

    assign last_plane = (plane == PLANE_W'(COLOR_BITS - 1));
    assign oe         = (show_cnt == '0);
    assign rd_addr    = col;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= WAIT_LINE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        rd_en      = 1'b0;
        run        = 1'b0;
        strobe     = 1'b0;
        line_ack   = 1'b0;
        frame_done = 1'b0;
        case (state)
            WAIT_LINE:  if (line_valid) next_state = SHIFT;
            SHIFT: begin
                rd_en = (step == STEP_FETCH);
                run   = (step == STEP_CLOCK);
                if (fall_en && row_done) next_state = LATCH_WAIT;
            end
            LATCH_WAIT: if (show_cnt == '0) next_state = LATCH;
            LATCH: begin
                strobe     = 1'b1;
                line_ack   = last_plane;
                frame_done = last_plane && (line == LINE_W'(SCAN_LINES - 1));
                next_state = last_plane ? WAIT_LINE : SHIFT;
            end
            default: next_state = WAIT_LINE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step        <= STEP_FETCH;
            col         <= '0;
            plane       <= '0;
            line        <= '0;
            show_cnt    <= '0;
            row_done    <= 1'b0;
            rgb         <= '0;
            line_select <= '0;
        end else begin
            if (state == LATCH)       show_cnt <= SHOW_W'(BASE_TICKS) << plane;
            else if (show_cnt != '0)  show_cnt <= show_cnt - 1'b1;

            // Row address only moves while blanked, at the first plane's latch
            if (state == LATCH_WAIT && next_state == LATCH && plane == '0)
                line_select <= line;

            if (state == SHIFT) begin
                case (step)
                    STEP_FETCH: step <= STEP_LOAD;
                    STEP_LOAD: begin
                        rgb  <= plane_bits;
                        step <= STEP_CLOCK;
                    end
                    STEP_CLOCK: begin
                        if (rise_en) begin
                            if (col == COL_W'(PIXELS - 1)) begin
                                col      <= '0;
                                row_done <= 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end
                        if (fall_en) step <= STEP_FETCH;
                    end
                    default: step <= STEP_FETCH;
                endcase
            end

            if (state == LATCH_WAIT) row_done <= 1'b0;

            if (state == LATCH) begin
                if (last_plane) begin
                    plane <= '0;
                    line  <= (line == LINE_W'(SCAN_LINES - 1)) ? '0 : line + 1'b1;
                end else begin
                    plane <= plane + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// Self-checking bench: a panel-level model (shift register contents, show times,
// line/frame sequencing) checks the scanner every cycle under random line data.
module tb_hub75_bcm_scanner;
    localparam int CH = 2, PX = 4, SL = 2, CB = 2, DIV = 2, BT = 16;
    localparam int NB = CH * 6;

    logic clk = 1'b0, reset = 1'b1, line_valid = 1'b0;
    logic line_ack, rd_en, led_clk, strobe, oe, frame_done;
    logic [$clog2(PX)-1:0] rd_addr;
    logic [NB*CB-1:0]      rd_data;
    logic [NB-1:0]         rgb;
    logic [$clog2(SL)-1:0] line_select;

    int total = 0, bad = 0;
    int fill_mode = 1;
    int pix [PX][NB];

    hub75_bcm_scanner #(
        .CHAINS(CH), .PIXELS(PX), .SCAN_LINES(SL),
        .COLOR_BITS(CB), .CLK_DIV(DIV), .BASE_TICKS(BT)
    ) dut (
        .clk(clk), .reset(reset), .line_valid(line_valid), .line_ack(line_ack),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .rgb(rgb),
        .led_clk(led_clk), .strobe(strobe), .oe(oe), .line_select(line_select),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Line buffer RAM, one-cycle read latency
    always @(posedge clk) begin
        if (rd_en)
            for (int j = 0; j < NB; j++) rd_data[j*CB +: CB] <= CB'(pix[rd_addr][j]);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fill_line();
        for (int c = 0; c < PX; c++)
            for (int j = 0; j < NB; j++)
                pix[c][j] = (fill_mode == 1) ? ((j < 6) ? 1 : 2)
                                             : int'($urandom_range(0, (1 << CB) - 1));
    endtask

    function automatic logic [NB-1:0] exp_col(input int c, input int p);
        logic [NB-1:0] v;
        for (int j = 0; j < NB; j++) v[j] = 1'((pix[c][j] >> p) & 1);
        return v;
    endfunction

    // Panel model state
    int show_rem, exp_plane, exp_line, exp_ls, rises, high_len, wait_cyc, oe_run;
    int n_latch = 0, n_ack = 0, n_frame = 0, n_rd = 0;
    logic last_led, last_strobe;
    logic [NB-1:0] cap[$];
    logic [NB-1:0] first_rgb[$];
    int oe_low[$];

    always @(negedge clk) begin
        if (reset) begin
            show_rem = 0; exp_plane = 0; exp_line = 0; exp_ls = 0;
            rises = 0; high_len = 0; wait_cyc = 0; oe_run = 0;
            last_led = 1'b0; last_strobe = 1'b0;
            cap.delete();
            fill_line();
        end else begin
            chk("oe", oe, show_rem == 0);
            if (!oe) oe_run++;
            else if (oe_run > 0) begin oe_low.push_back(oe_run); oe_run = 0; end
            if (show_rem > 0) show_rem--;
            if (rd_en) n_rd++;

            if (led_clk && !last_led) begin
                rises++;
                cap.push_back(rgb);
                high_len = 0;
                if (rises > PX) chk("extra_rise", rises, PX);
            end
            if (led_clk) begin
                high_len++;
                if (cap.size() > 0) chk("rgb_hold", rgb, cap[$]);
            end
            if (!led_clk && last_led) chk("clk_high_len", high_len, DIV);

            if (strobe) begin
                chk("strobe_width", last_strobe, 0);
                chk("strobe_cols", rises, PX);
                chk("strobe_ledclk", led_clk, 0);
                if (exp_plane == 0) exp_ls = exp_line % SL;
                for (int c = 0; c < PX; c++)
                    if (c < cap.size()) chk("shift_data", cap[c], exp_col(c, exp_plane));
                n_latch++;
                first_rgb.push_back((cap.size() > 0) ? cap[0] : '0);
            end
            chk("line_select", line_select, exp_ls);
            chk("line_ack", line_ack, strobe && exp_plane == CB - 1);
            chk("frame_done", frame_done,
                strobe && exp_plane == CB - 1 && (exp_line % SL) == SL - 1);
            if (line_ack) n_ack++;
            if (frame_done) n_frame++;

            if (strobe) begin
                show_rem = BT << exp_plane;
                rises = 0; wait_cyc = 0;
                cap.delete();
                if (exp_plane == CB - 1) begin
                    exp_plane = 0; exp_line++;
                    fill_line();
                end else begin
                    exp_plane++;
                end
            end else if (rises == PX && !led_clk && show_rem == 0) begin
                // shifted and dark: the latch is due within a couple of cycles
                wait_cyc++;
                if (wait_cyc > 3) begin chk("latch_late", wait_cyc, 3); wait_cyc = 0; end
            end
            last_led = led_clk;
            last_strobe = strobe;
        end
    end

    task automatic wait_latches(input int n, input int budget);
        int i;
        i = 0;
        while (n_latch < n && i < budget) begin @(posedge clk); i++; end
        #1;
        if (n_latch < n) chk("latch_timeout", n_latch, n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, l0, r0, i;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;

        // Idle with no line available
        repeat (50) begin
            @(negedge clk);
            chk("idle_oe", oe, 1);
            chk("idle_strobe", strobe, 0);
            chk("idle_ledclk", led_clk, 0);
            chk("idle_ls", line_select, 0);
        end
        chk("idle_rd", n_rd, 0);

        // Fixed pattern: chain 0 channels = 1, chain 1 channels = 2
        line_valid = 1'b1;
        wait_latches(5, 3000);
        chk("p0_rgb", (first_rgb.size() > 0) ? first_rgb[0] : '0, 12'h03F);
        chk("p1_rgb", (first_rgb.size() > 1) ? first_rgb[1] : '0, 12'hFC0);
        chk("p0_show", (oe_low.size() > 0) ? oe_low[0] : 0, 16);
        chk("p1_show", (oe_low.size() > 1) ? oe_low[1] : 0, 32);
        chk("l1p0_show", (oe_low.size() > 2) ? oe_low[2] : 0, 16);
        chk("frames", n_frame, 1);
        chk("acks", n_ack, 2);
        chk("ls_wrap", line_select, 0);

        // Random line data, occasionally withholding the next line
        fill_mode = 0;
        for (int l = 0; l < 8; l++) begin
            a0 = n_ack; i = 0;
            while (n_ack == a0 && i < 2000) begin @(posedge clk); #1; i++; end
            if (n_ack == a0) chk("ack_timeout", n_ack, a0 + 1);
            if (l == 1 || $urandom_range(0, 1) == 1) begin
                line_valid = 1'b0;
                l0 = n_latch; r0 = n_rd;
                repeat (80) @(posedge clk);
                #1;
                chk("drop_strobes", n_latch, l0);
                chk("drop_reads", n_rd, r0);
                chk("drop_oe", oe, 1);
                line_valid = 1'b1;
            end
        end

        // Reset while shifting
        i = 0;
        while (!led_clk && i < 500) begin @(posedge clk); #1; i++; end
        chk("reach_shift", led_clk, 1);
        reset = 1'b1;
        #1;
        chk("rst_rgb", rgb, 0);
        chk("rst_ledclk", led_clk, 0);
        chk("rst_strobe", strobe, 0);
        chk("rst_oe", oe, 1);
        chk("rst_ls", line_select, 0);
        chk("rst_ack", line_ack, 0);
        chk("rst_frame", frame_done, 0);
        chk("rst_rden", rd_en, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        wait_latches(n_latch + 4, 3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hub75_bcm_scanner.md
Name: hub75_bcm_scanner

Overview:
- Next-generation HUB75 scan engine: replaces the per-pixel PWM comparator with binary-coded modulation (BCM) over COLOR_BITS bit-planes.
- Parametrised in chain count, panel width, scan lines and colour depth; runs on one clock, with the LED shift clock generated internally by a clock-enable divider.
- Sits between the line-buffer loader (ping-pong RAM, 1-cycle read latency) and the panel pins.

Parameters:
- CHAINS, 1, independent panel chains driven in parallel (6 data pins each).
- PIXELS, 64, columns shifted per bit-plane.
- SCAN_LINES, 16, multiplexed row addresses (line_select range 0..SCAN_LINES-1).
- COLOR_BITS, 8, bits per colour channel; also the number of BCM planes.
- CLK_DIV, 2, clk cycles per led_clk half-period (≥1).
- BASE_TICKS, 4, clk cycles of OE-on for plane 0; plane b is lit BASE_TICKS<<b cycles.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- line_valid  in  1  loader: buffer for the line being scanned is filled.
- line_ack  out  1  one-cycle pulse: line buffer fully consumed, loader may refill.
- rd_addr  out  $clog2(PIXELS)  pixel column read address.
- rd_en  out  1  read strobe; data appears on rd_data 1 cycle later.
- rd_data  in  CHAINS*6*COLOR_BITS  per chain {b1,g1,r1,b0,g0,r0}, chain 0 in the LSBs.
- rgb  out  CHAINS*6  per chain {b1,g1,r1,b0,g0,r0} bit-plane data.
- led_clk  out  1  panel shift clock.
- strobe  out  1  latch.
- oe  out  1  blank, high = LEDs off.
- line_select  out  $clog2(SCAN_LINES)  row address.
- frame_done  out  1  one-cycle pulse after the last plane of line SCAN_LINES-1 is latched.

Behaviour:
- Reset values: rgb=0, led_clk=0, strobe=0, oe=1, line_select=0, line_ack=0, frame_done=0, rd_en=0. FSM goes to WAIT_LINE, plane=0, line=0.
- Reset mid-operation forces the reset values within the same cycle (asynchronous reset); there is no partial latch.
- Shift FSM states:
  - WAIT_LINE: oe forced 1. Leave when line_valid=1 to go to SHIFT.
  - SHIFT: for each column c=0..PIXELS-1:
    - rd_en pulses with rd_addr=c.
    - One cycle later rgb = bit[plane] of each channel, driven while led_clk=0.
    - led_clk rises CLK_DIV cycles later and falls CLK_DIV cycles after that.
    - After the final falling edge go to LATCH_WAIT.
  - LATCH_WAIT: wait until the show counter is 0 (the previous plane has finished displaying).
  - LATCH: oe=1 and strobe=1 for exactly one cycle.
    - If plane==0, line_select takes the new line value in this same cycle.
    - Next cycle: strobe=0, oe=0, show counter loads BASE_TICKS<<plane.
- Show counter:
  - Decrements each cycle while nonzero; oe=0 while it is nonzero.
  - When it reaches 0, oe returns to 1.
  - The show counter must be at least COLOR_BITS+CLK_DIV wide to hold BASE_TICKS<<(COLOR_BITS-1).
- Shift/show overlap: shifting of plane p+1 overlaps display of plane p. If shifting finishes first, wait in LATCH_WAIT. If display finishes first, oe stays 1 until the latch.
- Plane and line advance:
  - After SHIFT of plane COLOR_BITS-1: pulse line_ack for one cycle, plane wraps to 0, line increments (wraps at SCAN_LINES-1 to 0).
  - Then go to WAIT_LINE; the show of the last plane continues meanwhile.
- line_valid low at a line boundary: panel stays blanked (oe=1) once the current show expires. No garbage is latched.
- frame_done pulses in the latch cycle of plane COLOR_BITS-1 of line SCAN_LINES-1.
- Width rule: rgb bit for chain k, channel ch (0..5) = rd_data[(k*6+ch)*COLOR_BITS + plane].

Decomposition:
- Shared package hub75_pkg:
  - FSM state enum {WAIT_LINE, SHIFT, LATCH_WAIT, LATCH}.
  - Channel index constants R0..B1.
  - Function for the show counter width.
- One natural sub-module: hub75_clk_gen (CLK_DIV divider). Produces led_clk plus one-cycle rise_en/fall_en strobes gated by a run input.

Test Plan (CHAINS=1, PIXELS=4, SCAN_LINES=2, COLOR_BITS=2, CLK_DIV=1, BASE_TICKS=2 unless stated):
- Reset with line_valid=0 for 50 cycles -> oe=1, strobe=0, led_clk=0, line_select=0 throughout.
- Line with all channels = 2'b01, line_valid=1 -> plane 0:
  - 4 led_clk rises with rgb=6'h3F.
  - strobe one cycle, then oe=0 for exactly 2 cycles.
- Same line, plane 1 -> rgb=6'h00 shifted; oe=0 for exactly 4 cycles after the second strobe.
- Line completion:
  - line_ack pulses once after the plane 1 shift.
  - line_select changes 0->1 only in the plane 0 latch cycle of line 1, with oe=1 in that cycle.
- Two complete lines -> frame_done pulses once, line_select wraps to 0; CHAINS=2 maps chain 1 data to rgb[11:6].
- Drop line_valid before line 1 -> after the final show expires, oe stays 1 and no strobe occurs. Raising line_valid resumes the scan. Asserting reset mid-SHIFT returns all outputs to their reset values immediately.
